uart_cmd_responder: RTL and testbench

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

---
 rtl/uart_rsp_pkg.sv | 33 +++
 rtl/uart_rsp_timer.sv | 31 +++
 rtl/uart_cmd_responder.sv | 154 +++++++++++++++
 tb/tb_uart_cmd_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rsp_pkg.sv
// Shared constants, status codes and FSM encoding for the UART command responder.
// No logic; imported by uart_cmd_responder and uart_rsp_timer.
package uart_rsp_pkg;

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;

  localparam logic [7:0] STAT_OK       = 8'h00;
  localparam logic [7:0] STAT_BAD_CHK  = 8'h01;
  localparam logic [7:0] STAT_BAD_CMD  = 8'h02;
  localparam logic [7:0] STAT_BAD_ADDR = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_RSP_SOF,
    S_RSP_STAT,
    S_RSP_DATA,
    S_RSP_CHK
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_rsp_timer.sv
// Inter-byte gap counter: expired pulses on the TIMEOUT_CYCLES-th consecutive gap cycle.
// Zero latency on expiry; clears whenever the gap is broken (byte consumed or frame left).
module uart_rsp_timer
  import uart_rsp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic gap,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = gap && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!gap || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Framed register read/write responder between RX/TX FIFOs; one byte per cycle in, EXEC is one cycle.
// Stalls on tx_full indefinitely; optional inter-byte timeout via UART_RSP_TIMEOUT_EN.
module uart_cmd_responder
  import uart_rsp_pkg::*;
#(
  parameter int REG_COUNT      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [7:0]  reg_addr,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
);

  localparam logic [8:0] ADDR_LIMIT = (REG_COUNT > 256) ? 9'd256 : 9'(REG_COUNT);

  state_t     state;
  logic [7:0] cmd_q;
  logic [7:0] data_q;
  logic [7:0] status_q;
  logic [7:0] rdata_q;
  logic       in_rx;
  logic       in_rsp;
  logic       timeout;
  logic [7:0] rx_status;

  assign in_rx  = state inside {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK};
  assign in_rsp = state inside {S_RSP_SOF, S_RSP_STAT, S_RSP_DATA, S_RSP_CHK};

  // State sits in IDLE during reset, so the pop must also be gated by reset_n.
  assign rx_rd = reset_n && in_rx && !rx_empty;
  assign tx_wr = in_rsp && !tx_full;

`ifdef UART_RSP_TIMEOUT_EN
  logic in_frame;
  assign in_frame = state inside {S_CMD, S_ADDR, S_DATA, S_CHK};

  uart_rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .gap     (in_frame && rx_empty),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    rx_status = STAT_OK;
    if (rx_data != (cmd_q ^ reg_addr ^ data_q)) begin
      rx_status = STAT_BAD_CHK;
    end else if (cmd_q != CMD_RD && cmd_q != CMD_WR) begin
      rx_status = STAT_BAD_CMD;
    end else if ({1'b0, reg_addr} >= ADDR_LIMIT) begin
      rx_status = STAT_BAD_ADDR;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_RSP_SOF:  tx_data = SOF_RSP;
      S_RSP_STAT: tx_data = status_q;
      S_RSP_DATA: tx_data = rdata_q;
      S_RSP_CHK:  tx_data = status_q ^ rdata_q;
      default:    tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cmd_q     <= 8'h00;
      data_q    <= 8'h00;
      status_q  <= 8'h00;
      rdata_q   <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wr    <= 1'b0;
      reg_wdata <= 8'h00;
      ok_count  <= 16'h0000;
      err_count <= 16'h0000;
    end else begin
      reg_wr <= 1'b0;
      if (timeout) begin
        state     <= S_IDLE;
        err_count <= sat_inc(err_count);
      end else begin
        case (state)
          S_IDLE: begin
            if (!rx_empty && rx_data == SOF_REQ) state <= S_CMD;
          end
          S_CMD: begin
            if (!rx_empty) begin
              cmd_q  <= rx_data;
              data_q <= 8'h00;
              state  <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (!rx_empty) begin
              reg_addr <= rx_data;
              state    <= (cmd_q == CMD_WR) ? S_DATA : S_CHK;
            end
          end
          S_DATA: begin
            if (!rx_empty) begin
              data_q <= rx_data;
              state  <= S_CHK;
            end
          end
          S_CHK: begin
            if (!rx_empty) begin
              status_q <= rx_status;
              // Strobe is registered so it lands exactly in the EXEC cycle.
              if (rx_status == STAT_OK && cmd_q == CMD_WR) begin
                reg_wr    <= 1'b1;
                reg_wdata <= data_q;
              end
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (status_q == STAT_OK) begin
              ok_count <= sat_inc(ok_count);
              rdata_q  <= (cmd_q == CMD_WR) ? data_q : reg_rdata;
            end else begin
              err_count <= sat_inc(err_count);
              rdata_q   <= 8'h00;
            end
            state <= S_RSP_SOF;
          end
          S_RSP_SOF:  if (!tx_full) state <= S_RSP_STAT;
          S_RSP_STAT: if (!tx_full) state <= S_RSP_DATA;
          S_RSP_DATA: if (!tx_full) state <= S_RSP_CHK;
          S_RSP_CHK:  if (!tx_full) state <= S_IDLE;
          default:    state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: FWFT RX queue model, TX capture queue, reg port monitor.
// Register read data model: reg_rdata = reg_addr ^ 0x3F (addr 03 -> 3C).
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd;
  logic        tx_full = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [7:0]  reg_addr;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  logic [7:0] q[$];
  logic [7:0] txq[$];
  logic       pop_seen = 1'b0;
  logic       push_seen = 1'b0;
  logic [7:0] tx_seen = 8'h00;
  int         wr_cnt = 0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  uart_cmd_responder #(
    .REG_COUNT(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rx_rd     (rx_rd),
    .tx_full   (tx_full),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ok_count  (ok_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  assign reg_rdata = reg_addr ^ 8'h3F;

  always @(posedge clk) begin
    pop_seen  <= rx_rd;
    push_seen <= tx_wr;
    tx_seen   <= tx_data;
    if (reg_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= reg_addr;
      wr_data <= reg_wdata;
    end
  end

  always @(negedge clk) begin
    if (pop_seen && q.size() > 0) q.delete(0);
    if (push_seen) txq.push_back(tx_seen);
    rx_empty = (q.size() == 0);
    rx_data  = (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    if (n > 0) q.push_back(b0);
    if (n > 1) q.push_back(b1);
    if (n > 2) q.push_back(b2);
    if (n > 3) q.push_back(b3);
    if (n > 4) q.push_back(b4);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int c = 0;
    while (txq.size() < n && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk({tag, "_rsp_arrived"}, 16'(txq.size() >= n), 16'd1);
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] s, input logic [7:0] d);
    logic [7:0] exp_b [4];
    logic [7:0] b;
    exp_b[0] = 8'h5A;
    exp_b[1] = s;
    exp_b[2] = d;
    exp_b[3] = s ^ d;
    wait_tx(tag, 4);
    for (int i = 0; i < 4; i++) begin
      b = 8'hxx;
      if (txq.size() > 0) begin
        b = txq[0];
        txq.delete(0);
      end
      chk($sformatf("%s_byte%0d", tag, i), {8'h00, b}, {8'h00, exp_b[i]});
    end
  endtask

  initial begin
    int bad_tx;
    int bad_rx;
    int c;
    logic [15:0] err_before;

    // Reset with a byte already waiting: nothing may be popped.
    q.push_back(8'h11);
    cycles(3);
    chk("rst_rx_rd", {15'd0, rx_rd}, 16'd0);
    chk("rst_tx_wr", {15'd0, tx_wr}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
    chk("rst_reg_addr", {8'd0, reg_addr}, 16'd0);
    chk("rst_reg_wr", {15'd0, reg_wr}, 16'd0);
    chk("rst_reg_wdata", {8'd0, reg_wdata}, 16'd0);
    chk("rst_ok", ok_count, 16'd0);
    chk("rst_err", err_count, 16'd0);
    reset_n = 1'b1;
    cycles(4);

    // Write 0x7E to register 3.
    send(5, 8'hA5, 8'h02, 8'h03, 8'h7E, 8'h7F);
    expect_rsp("wr", 8'h00, 8'h7E);
    chk("wr_pulses", 16'(wr_cnt), 16'd1);
    chk("wr_addr", {8'd0, wr_addr}, 16'h0003);
    chk("wr_data", {8'd0, wr_data}, 16'h007E);
    chk("wr_ok", ok_count, 16'd1);

    // Read register 3.
    send(4, 8'hA5, 8'h01, 8'h03, 8'h02, 8'h00);
    expect_rsp("rd", 8'h00, 8'h3C);
    chk("rd_no_wr", 16'(wr_cnt), 16'd1);
    chk("rd_ok", ok_count, 16'd2);
    chk("rd_err", err_count, 16'd0);

    // Bad checksum then out-of-range address.
    send(5, 8'hA5, 8'h02, 8'h03, 8'h7E, 8'h00);
    expect_rsp("badchk", 8'h01, 8'h00);
    chk("badchk_no_wr", 16'(wr_cnt), 16'd1);
    send(4, 8'hA5, 8'h01, 8'h20, 8'h21, 8'h00);
    expect_rsp("badaddr", 8'h03, 8'h00);
    chk("bad_err", err_count, 16'd2);
    chk("bad_ok", ok_count, 16'd2);

    // Leading garbage and an invalid command (no DATA byte expected).
    send(2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00);
    send(4, 8'hA5, 8'h05, 8'h00, 8'h05, 8'h00);
    expect_rsp("badcmd", 8'h02, 8'h00);
    chk("badcmd_err", err_count, 16'd3);

    // Backpressure during RSP_STAT, with a second frame queued behind it.
    send(4, 8'hA5, 8'h01, 8'h05, 8'h04, 8'h00);
    c = 0;
    while (txq.size() < 1 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    tx_full = 1'b1;
    chk("hold_sof_seen", 16'(txq.size()), 16'd1);
    send(4, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00);
    bad_tx = 0;
    bad_rx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tx_wr !== 1'b0) bad_tx++;
      if (rx_rd !== 1'b0) bad_rx++;
    end
    chk("hold_tx_wr_cycles", 16'(bad_tx), 16'd0);
    chk("hold_rx_rd_cycles", 16'(bad_rx), 16'd0);
    chk("hold_tx_count", 16'(txq.size()), 16'd1);
    chk("hold_rx_kept", 16'(q.size()), 16'd4);
    tx_full = 1'b0;
    expect_rsp("hold1", 8'h00, 8'h3A);
    expect_rsp("hold2", 8'h00, 8'h3F);
    chk("hold_ok", ok_count, 16'd4);

`ifdef UART_RSP_TIMEOUT_EN
    // Truncated frame: the gap timer abandons it silently.
    err_before = err_count;
    send(2, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
    cycles(40);
    chk("to_not_yet", err_count, err_before);
    cycles(40);
    chk("to_err", err_count, err_before + 16'd1);
    chk("to_no_tx", 16'(txq.size()), 16'd0);
    send(4, 8'hA5, 8'h01, 8'h07, 8'h06, 8'h00);
    expect_rsp("to_after", 8'h00, 8'h38);
`else
    err_before = err_count;
`endif

    // Reset mid-frame: a fresh frame after release must parse from scratch.
    send(2, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
    cycles(4);
    reset_n = 1'b0;
    send(4, 8'hA5, 8'h01, 8'h03, 8'h02, 8'h00);
    cycles(3);
    chk("mid_rst_rx_rd", {15'd0, rx_rd}, 16'd0);
    chk("mid_rst_tx_wr", {15'd0, tx_wr}, 16'd0);
    chk("mid_rst_ok", ok_count, 16'd0);
    chk("mid_rst_err", err_count, 16'd0);
    reset_n = 1'b1;
    expect_rsp("post_rst", 8'h00, 8'h3C);
    chk("post_rst_ok", ok_count, 16'd1);
    chk("post_rst_err", err_count, 16'd0);
    cycles(10);
    chk("tx_leftover", 16'(txq.size()), 16'd0);
    chk("rx_leftover", 16'(q.size()), 16'd0);
    chk("final_wr_pulses", 16'(wr_cnt), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
